// File: rtl/ans_decoder.sv
// ans_decoder: streaming rANS decoder, the inverse of ans_encoder.
//
// A load puts the encoder's final state into the coder state register. Each
// step then drives the lookup slot (state mod total_count) to an external
// frequency table, decodes one symbol from the table's answer and presents it
// on out/out_vld. When the state drops below total_count it pulls
// SYM_WIDTH-bit compressed words from in/in_vld. Words are consumed in the
// reverse of the order the encoder emitted them. This continues until the
// state is back in range [total_count, b*total_count).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 clock enable; low freezes every register
//   total_count         sum of all symbol counts (L), nonzero, stable while busy
//   init_state/len/vld  load request; init_rdy high only while idle
//   slot                combinational lookup address = state mod total_count
//   lk_symbol/count/cumulative  table answer for slot
//   in, in_vld, in_rdy  compressed-word input handshake
//   out, out_vld, out_rdy  decoded-symbol output handshake
//   dec_state           current coder state
//   done                one-cycle pulse once init_len symbols are accepted
//   err                 sticky zero-count error, cleared by reset or next load

`ifndef SYM_WIDTH
`define SYM_WIDTH 8
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module ans_decoder (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic [`STATE_WIDTH-1:0]           total_count,
  input  logic [`STATE_WIDTH-1:0]           init_state,
  input  logic [15:0]                       init_len,
  input  logic                              init_vld,
  output logic                              init_rdy,
  output logic [`STATE_WIDTH-1:0]           slot,
  input  logic [`SYM_WIDTH-1:0]             lk_symbol,
  input  logic [`CNT_WIDTH-1:0]             lk_count,
  input  logic [`SYM_WIDTH+`CNT_WIDTH-1:0]  lk_cumulative,
  input  logic [`SYM_WIDTH-1:0]             in,
  input  logic                              in_vld,
  output logic                              in_rdy,
  output logic [`SYM_WIDTH-1:0]             out,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [`STATE_WIDTH-1:0]           dec_state,
  output logic                              done,
  output logic                              err
);

  localparam int SYMW = `SYM_WIDTH;
  localparam int CNTW = `CNT_WIDTH;
  localparam int STW  = `STATE_WIDTH;
  // Wide enough for count * quotient before truncation back to the state.
  localparam int PW   = STW + CNTW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_EMIT,
    S_RENORM
  } fsm_e;

  fsm_e             fsm_q;
  logic [STW-1:0]   state_q;
  logic [15:0]      remaining_q;
  logic [SYMW-1:0]  out_q;
  logic             out_vld_q;
  logic             in_rdy_q;
  logic             init_rdy_q;
  logic             done_q;
  logic             err_q;

  // Combinational arithmetic feeding the registered FSM.
  logic [STW-1:0]   quot_d;
  logic [STW-1:0]   slot_d;
  logic [PW-1:0]    decode_wide_d;
  logic [STW-1:0]   lookup_state_d;
  logic [STW-1:0]   renorm_state_d;

  assign quot_d = state_q / total_count;
  assign slot_d = state_q % total_count;

  // x' = count * floor(x / L) + (x mod L) - cumulative, computed wide so the
  // intermediate product cannot wrap. The result is within STATE_WIDTH
  // whenever the state entered LOOKUP in range.
  assign decode_wide_d  = PW'(lk_count) * PW'(quot_d) + PW'(slot_d) - PW'(lk_cumulative);
  assign lookup_state_d = decode_wide_d[STW-1:0];

  // Renormalisation shifts one compressed word into the low end of the state.
  assign renorm_state_d = {state_q[STW-SYMW-1:0], in};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge register values regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is sampled on the clock edge (synchronous), so it sits
      // inside the clocked block rather than in the sensitivity list.
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      remaining_q <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      in_rdy_q    <= 1'b0;
      init_rdy_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (init_vld && init_rdy_q) begin
            state_q     <= init_state;
            remaining_q <= init_len;
            err_q       <= 1'b0;
            if (init_len == 16'd0) begin
              // Empty job: acknowledge immediately and stay ready.
              done_q <= 1'b1;
            end else begin
              init_rdy_q <= 1'b0;
              fsm_q      <= S_LOOKUP;
            end
          end
        end

        S_LOOKUP: begin
          if (lk_count == '0) begin
            // A zero count cannot own the slot; abandon the job.
            err_q      <= 1'b1;
            init_rdy_q <= 1'b1;
            fsm_q      <= S_IDLE;
          end else begin
            out_q     <= lk_symbol;
            out_vld_q <= 1'b1;
            state_q   <= lookup_state_d;
            fsm_q     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (out_vld_q && out_rdy) begin
            out_vld_q   <= 1'b0;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              // Last symbol: the remaining state is the decoder's end state,
              // so no further words are pulled.
              done_q     <= 1'b1;
              init_rdy_q <= 1'b1;
              fsm_q      <= S_IDLE;
            end else if (state_q < total_count) begin
              in_rdy_q <= 1'b1;
              fsm_q    <= S_RENORM;
            end else begin
              fsm_q <= S_LOOKUP;
            end
          end
        end

        S_RENORM: begin
          if (in_vld && in_rdy_q) begin
            state_q <= renorm_state_d;
            if (renorm_state_d >= total_count) begin
              in_rdy_q <= 1'b0;
              fsm_q    <= S_LOOKUP;
            end
          end
        end

        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign slot      = slot_d;
  assign init_rdy  = init_rdy_q;
  assign in_rdy    = in_rdy_q;
  assign out       = out_q;
  assign out_vld   = out_vld_q;
  assign dec_state = state_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ans_decoder.sv
// Testbench for ans_decoder. A small frequency table (total 4: A count 1
// cumulative 0 on slot 0, B count 3 cumulative 1 on slots 1-3) answers the
// lookup. Stimulus pushes each expected {symbol, end state} into a scoreboard
// queue. A monitor pops and compares on every accepted output symbol.

`ifndef SYM_WIDTH
`define SYM_WIDTH 8
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module tb_ans_decoder;

  localparam logic [7:0] SYM_A = 8'h41;
  localparam logic [7:0] SYM_B = 8'h42;

  typedef struct {
    logic [`SYM_WIDTH-1:0]   sym;
    logic [`STATE_WIDTH-1:0] state;
  } exp_t;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              ena;
  logic [`STATE_WIDTH-1:0]           total_count;
  logic [`STATE_WIDTH-1:0]           init_state;
  logic [15:0]                       init_len;
  logic                              init_vld;
  logic                              init_rdy;
  logic [`STATE_WIDTH-1:0]           slot;
  logic [`SYM_WIDTH-1:0]             lk_symbol;
  logic [`CNT_WIDTH-1:0]             lk_count;
  logic [`SYM_WIDTH+`CNT_WIDTH-1:0]  lk_cumulative;
  logic [`SYM_WIDTH-1:0]             in;
  logic                              in_vld;
  logic                              in_rdy;
  logic [`SYM_WIDTH-1:0]             out;
  logic                              out_vld;
  logic                              out_rdy;
  logic [`STATE_WIDTH-1:0]           dec_state;
  logic                              done;
  logic                              err;

  logic force_zero = 1'b0;

  int   checks      = 0;
  int   failures    = 0;
  int   done_cnt    = 0;
  int   in_rdy_seen = 0;
  int   vld_seen    = 0;
  exp_t sb[$];

  ans_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .total_count   (total_count),
    .init_state    (init_state),
    .init_len      (init_len),
    .init_vld      (init_vld),
    .init_rdy      (init_rdy),
    .slot          (slot),
    .lk_symbol     (lk_symbol),
    .lk_count      (lk_count),
    .lk_cumulative (lk_cumulative),
    .in            (in),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .out           (out),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .dec_state     (dec_state),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Frequency table model.
  always_comb begin
    lk_symbol     = SYM_B;
    lk_count      = 8'd3;
    lk_cumulative = 16'd1;
    if (slot == 16'd0) begin
      lk_symbol     = SYM_A;
      lk_count      = 8'd1;
      lk_cumulative = 16'd0;
    end
    if (force_zero) lk_count = 8'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_rdy && out_vld) check("in_rdy_out_vld_exclusive", 32'd1, 32'd0);
      if (ena && done) done_cnt++;
      if (in_rdy) in_rdy_seen++;
      if (out_vld) vld_seen++;
      if (ena && out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_symbol", 32'(out), 32'(e.sym));
          check("sb_state", 32'(dec_state), 32'(e.state));
        end
      end
    end
  end

  task automatic load(input logic [15:0] st, input logic [15:0] len);
    init_state = st;
    init_len   = len;
    init_vld   = 1'b1;
    cyc();
    init_vld   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done) break;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_rdy"}, 32'(init_rdy), 32'd1);
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'd0);
    check({tag, "_out_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_dec_state"}, 32'(dec_state), 32'd0);
  endtask

  initial begin
    int d0;
    int r0;
    int v0;
    logic [47:0] snap;

    rst_n       = 1'b0;
    ena         = 1'b1;
    total_count = 16'd4;
    init_state  = '0;
    init_len    = '0;
    init_vld    = 1'b0;
    in          = '0;
    in_vld      = 1'b0;
    out_rdy     = 1'b1;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Test 1: state 7, one symbol -> B, end state 5, no renorm.
    d0 = done_cnt;
    r0 = in_rdy_seen;
    sb.push_back('{sym: SYM_B, state: 16'd5});
    load(16'd7, 16'd1);
    check("t1_init_rdy_low", 32'(init_rdy), 32'd0);
    check("t1_no_vld_yet", 32'(out_vld), 32'd0);
    cyc();
    check("t1_vld_after_2", 32'(out_vld), 32'd1);
    wait_done("t1_done", 10);
    cyc();
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_end_state", 32'(dec_state), 32'd5);
    check("t1_init_rdy", 32'(init_rdy), 32'd1);
    check("t1_no_in_rdy", 32'(in_rdy_seen - r0), 32'd0);

    // Test 2: state 4, two symbols, one word 0x05 pulled in between.
    d0 = done_cnt;
    sb.push_back('{sym: SYM_A, state: 16'd1});
    sb.push_back('{sym: SYM_B, state: 16'd195});
    load(16'd4, 16'd2);
    for (int i = 0; i < 10 && !in_rdy; i++) cyc();
    check("t2_in_rdy", 32'(in_rdy), 32'd1);
    check("t2_state_low", 32'(dec_state), 32'd1);
    in     = 8'h05;
    in_vld = 1'b1;
    cyc();
    in_vld = 1'b0;
    check("t2_state_261", 32'(dec_state), 32'd261);
    check("t2_in_rdy_drop", 32'(in_rdy), 32'd0);
    wait_done("t2_done", 10);
    check("t2_end_state", 32'(dec_state), 32'd195);
    cyc();
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // Test 3: back-pressure on the output for five cycles.
    d0 = done_cnt;
    out_rdy = 1'b0;
    sb.push_back('{sym: SYM_B, state: 16'd5});
    load(16'd7, 16'd1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_vld", 32'(out_vld), 32'd1);
      check("t3_hold_out", 32'(out), 32'(SYM_B));
      check("t3_no_in_rdy", 32'(in_rdy), 32'd0);
      check("t3_no_done", 32'(done), 32'd0);
      cyc();
    end
    out_rdy = 1'b1;
    cyc();
    check("t3_done", 32'(done), 32'd1);
    cyc();
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // Test 4: zero count from the table raises err and returns to idle.
    v0 = vld_seen;
    force_zero = 1'b1;
    load(16'd7, 16'd1);
    cyc();
    check("t4_err", 32'(err), 32'd1);
    check("t4_init_rdy", 32'(init_rdy), 32'd1);
    check("t4_no_vld", 32'(out_vld), 32'd0);
    cyc();
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_vld_never", 32'(vld_seen - v0), 32'd0);
    force_zero = 1'b0;
    sb.push_back('{sym: SYM_B, state: 16'd5});
    load(16'd7, 16'd1);
    check("t4_err_cleared", 32'(err), 32'd0);
    wait_done("t4_reload_done", 10);
    cyc();

    // Test 5a: reset while waiting for a compressed word.
    sb.push_back('{sym: SYM_A, state: 16'd1});
    load(16'd4, 16'd2);
    for (int i = 0; i < 10 && !in_rdy; i++) cyc();
    check("t5_in_renorm", 32'(in_rdy), 32'd1);
    rst_n = 1'b0;
    cyc();
    check_reset_outputs("t5_reset");
    rst_n = 1'b1;
    cyc();

    // Test 5b: ena low freezes a symbol waiting in EMIT.
    out_rdy = 1'b0;
    sb.push_back('{sym: SYM_B, state: 16'd5});
    load(16'd7, 16'd1);
    cyc();
    check("t5_vld_before_freeze", 32'(out_vld), 32'd1);
    snap = {out, dec_state, 6'd0, init_rdy, in_rdy, out_vld, done, err, 13'd0};
    ena      = 1'b0;
    out_rdy  = 1'b1;
    init_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t5_frozen",
            32'({out, dec_state, 6'd0, init_rdy, in_rdy, out_vld, done, err, 13'd0} ^ snap),
            32'd0);
    end
    init_vld = 1'b0;
    ena      = 1'b1;
    cyc();
    check("t5_resume_done", 32'(done), 32'd1);
    cyc();

    // Test 6: empty job.
    d0 = done_cnt;
    v0 = vld_seen;
    load(16'd7, 16'd0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_init_rdy", 32'(init_rdy), 32'd1);
    repeat (3) cyc();
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);
    check("t6_no_vld", 32'(vld_seen - v0), 32'd0);
    check("t6_init_rdy_stays", 32'(init_rdy), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
